// File: rtl/bus_target_pkg.sv
// Shared types and helpers for the bus memory target: FSM states, widths,
// byte-address to word-index conversion and the access range check.
package bus_target_pkg;

  localparam int BEATS_W = 8;
  localparam int WORD_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WR_DRAIN,
    S_RD_FETCH,
    S_RD_DATA,
    S_RD_END,
    S_ERROR
  } state_t;

  // Word offset of a byte address relative to the base; addresses below the
  // base wrap to a huge offset, which the range check then rejects.
  function automatic logic [WORD_W-1:0] word_offset(input logic [WORD_W-1:0] addr,
                                                    input logic [WORD_W-1:0] base);
    logic [WORD_W-1:0] diff;
    diff = addr - base;
    return {2'b00, diff[WORD_W-1:2]};
  endfunction

  // True when the access is misaligned, starts outside the memory, or its
  // last beat would fall past the final word.
  function automatic logic access_bad(input logic [WORD_W-1:0]  addr,
                                      input logic [WORD_W-1:0]  base,
                                      input logic [WORD_W-1:0]  size,
                                      input logic [BEATS_W-1:0] burst);
    logic [WORD_W-1:0] off;
    logic [WORD_W:0]   last;
    off  = word_offset(addr, base);
    last = {1'b0, off} + {{(WORD_W+1-BEATS_W){1'b0}}, burst};
    return (addr[1:0] != 2'b00) || (off >= size) || (last >= {1'b0, size});
  endfunction

endpackage

// File: rtl/bus_target_ram.sv
// Word memory built from four independent byte lanes. One shared address per
// cycle; each lane has its own write enable and a registered read.
module bus_target_ram
  import bus_target_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              re,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q;

      // Lane write and synchronous lane read on the shared address
      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[addr] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          q <= mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = q;
    end
  endgenerate

endmodule

// File: rtl/bus_memory_target.sv
// Bus responder backed by a byte-enabled word RAM. Handles framed burst
// writes (with optional periodic throttling) and burst reads (with initiator
// stalls), and reports misaligned or out-of-range accesses.
module bus_memory_target
  import bus_target_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h5555_0000,
  parameter int          SIZE_WORDS = 256,
  parameter int          BUSY_EVERY = 0
) (
  input  logic               system_clock,
  input  logic               system_reset,
  input  logic [WORD_W-1:0]  address_dataIN,
  input  logic [3:0]         byte_enableIN,
  input  logic [BEATS_W-1:0] burst_sizeIN,
  input  logic               read_n_writeIN,
  input  logic               begin_transactionIN,
  input  logic               end_transactionIN,
  input  logic               data_validIN,
  input  logic               busyIN,
  output logic [WORD_W-1:0]  address_dataOUT,
  output logic               data_validOUT,
  output logic               end_transactionOUT,
  output logic               busyOUT,
  output logic               errorOUT
);

  localparam int                AW       = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  localparam logic [WORD_W-1:0] SIZE_L   = WORD_W'(SIZE_WORDS);
  localparam logic [31:0]       THR_LAST = (BUSY_EVERY > 0) ? 32'(BUSY_EVERY - 1) : 32'd0;

  state_t             state_q;
  logic [AW-1:0]      idx_q;
  logic [BEATS_W:0]   beat_q;     // one bit wider so burst+1 beats fit
  logic [BEATS_W-1:0] burst_q;
  logic [3:0]         be_q;
  logic               rnw_q;
  logic [31:0]        thr_cnt_q;
  logic               dvalid_q;
  logic               end_q;
  logic               err_q;
  logic               busy_q;

  logic [AW-1:0]      begin_idx;
  logic               begin_bad;
  logic               wr_accept;
  logic               rd_consume;
  logic               ram_re;
  logic [3:0]         ram_we;
  logic [AW-1:0]      ram_addr;
  logic [WORD_W-1:0]  ram_rdata;

  // Decode of the begin cycle plus RAM port steering. A consumed read beat
  // prefetches the next word; a stalled beat re-reads the same word.
  always_comb begin
    begin_idx  = AW'(word_offset(address_dataIN, BASE_ADDR));
    begin_bad  = access_bad(address_dataIN, BASE_ADDR, SIZE_L, burst_sizeIN);
    wr_accept  = (state_q == S_WRITE) && data_validIN && !busy_q &&
                 (beat_q <= {1'b0, burst_q});
    rd_consume = (state_q == S_RD_DATA) && !busyIN && !end_transactionIN;
    ram_re     = (state_q == S_RD_FETCH) || (state_q == S_RD_DATA);
    ram_we     = wr_accept ? be_q : 4'b0000;
    ram_addr   = rd_consume ? (idx_q + AW'(1)) : idx_q;
  end

  bus_target_ram #(
    .DEPTH (SIZE_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (system_clock),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (address_dataIN),
    .rdata (ram_rdata)
  );

  // Transaction FSM with registered strobes; strobes default low each cycle
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      be_q      <= '0;
      rnw_q     <= 1'b0;
      thr_cnt_q <= '0;
      dvalid_q  <= 1'b0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (begin_transactionIN) begin
            idx_q     <= begin_idx;
            beat_q    <= '0;
            burst_q   <= burst_sizeIN;
            be_q      <= byte_enableIN;
            rnw_q     <= read_n_writeIN;
            thr_cnt_q <= '0;
            if (begin_bad) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              end_q   <= 1'b1;
            end else if (read_n_writeIN) begin
              state_q <= S_RD_FETCH;
            end else begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (end_transactionIN) begin
            state_q <= S_IDLE;
          end else if (wr_accept) begin
            idx_q  <= idx_q + AW'(1);
            beat_q <= beat_q + 9'd1;
            if (BUSY_EVERY > 0) begin
              if (thr_cnt_q == THR_LAST) begin
                busy_q    <= 1'b1;
                thr_cnt_q <= '0;
              end else begin
                thr_cnt_q <= thr_cnt_q + 32'd1;
              end
            end
          end
        end
        S_WR_DRAIN: begin
          if (end_transactionIN) begin
            state_q <= S_IDLE;
          end
        end
        S_RD_FETCH: begin
          if (end_transactionIN) begin
            state_q <= S_IDLE;
          end else begin
            state_q  <= S_RD_DATA;
            dvalid_q <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (end_transactionIN) begin
            state_q <= S_IDLE;
          end else if (busyIN) begin
            dvalid_q <= 1'b1;
          end else if (beat_q == {1'b0, burst_q}) begin
            state_q <= S_RD_END;
            end_q   <= 1'b1;
          end else begin
            idx_q    <= idx_q + AW'(1);
            beat_q   <= beat_q + 9'd1;
            dvalid_q <= 1'b1;
          end
        end
        S_RD_END: begin
          state_q <= S_IDLE;
        end
        S_ERROR: begin
          if (!rnw_q && !end_transactionIN) begin
            state_q <= S_WR_DRAIN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign address_dataOUT    = dvalid_q ? ram_rdata : '0;
  assign data_validOUT      = dvalid_q;
  assign end_transactionOUT = end_q;
  assign busyOUT            = busy_q;
  assign errorOUT           = err_q;

endmodule

// File: tb/tb_bus_memory_target.sv
// Bench for bus_memory_target: transaction-level model (word array plus
// per-cycle expected outputs derived from the protocol rules) and a single
// negedge compare process, with directed scenarios and randomized traffic.
module tb_bus_memory_target;

  localparam logic [31:0] BASE = 32'h5555_0000;
  localparam int          SIZE = 256;
  localparam int          BEV  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  always #5 clk = ~clk;

  bus_memory_target #(
    .BASE_ADDR  (BASE),
    .SIZE_WORDS (SIZE),
    .BUSY_EVERY (BEV)
  ) dut (
    .system_clock        (clk),
    .system_reset        (rst),
    .address_dataIN      (address_dataIN),
    .byte_enableIN       (byte_enableIN),
    .burst_sizeIN        (burst_sizeIN),
    .read_n_writeIN      (read_n_writeIN),
    .begin_transactionIN (begin_transactionIN),
    .end_transactionIN   (end_transactionIN),
    .data_validIN        (data_validIN),
    .busyIN              (busyIN),
    .address_dataOUT     (address_dataOUT),
    .data_validOUT       (data_validOUT),
    .end_transactionOUT  (end_transactionOUT),
    .busyOUT             (busyOUT),
    .errorOUT            (errorOUT)
  );

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] mem_m [SIZE];
  logic [31:0] wq [$];
  int          model_busy_cnt = 0;

  // expected outputs for the current cycle
  logic        exp_dv = 1'b0, exp_end = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
  logic [31:0] exp_data = 32'h0;
  bit          chk_en = 1'b0;

  int dut_dv_cnt = 0, dut_busy_cnt = 0, dut_err_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // one compare per cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_validOUT", data_validOUT, exp_dv);
      check("address_dataOUT", address_dataOUT, exp_data);
      check("end_transactionOUT", end_transactionOUT, exp_end);
      check("errorOUT", errorOUT, exp_err);
      check("busyOUT", busyOUT, exp_busy);
      if (data_validOUT) dut_dv_cnt++;
      if (busyOUT) dut_busy_cnt++;
      if (errorOUT) dut_err_cnt++;
    end
  end

  function automatic bit bad_m(input logic [31:0] a, input logic [7:0] b);
    longint off;
    off = longint'(a) - longint'(BASE);
    if ((a % 4) != 0) return 1'b1;
    if (off < 0) return 1'b1;
    if ((off / 4) + longint'(b) >= SIZE) return 1'b1;
    return 1'b0;
  endfunction

  // advance to the next cycle; inputs idle and outputs expected low
  task automatic tick();
    @(posedge clk);
    #1;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
    read_n_writeIN      = 1'b0;
    address_dataIN      = $urandom;
    byte_enableIN       = 4'($urandom);
    burst_sizeIN        = 8'($urandom);
    exp_dv = 1'b0; exp_end = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_data = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [7:0] b,
                          input int nbeats, input int vpct);
    int idx, sent, acc;
    logic busy_m, busy_next, have;
    logic [31:0] d;
    tick();
    begin_transactionIN = 1'b1; address_dataIN = a; byte_enableIN = be;
    burst_sizeIN = b; read_n_writeIN = 1'b0;
    if (bad_m(a, b)) begin
      tick();
      exp_err = 1'b1; exp_end = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
        data_validIN = 1'b1; address_dataIN = $urandom;
        tick();
      end
      end_transactionIN = 1'b1;
      tick();
      $display("WR  addr=%h burst=%0d -> error", a, b);
      return;
    end
    idx = int'((a - BASE) >> 2);
    sent = 0; acc = 0; busy_m = 1'b0; have = 1'b0; d = 32'h0;
    tick();
    while (sent < nbeats) begin
      exp_busy = busy_m;
      if (busy_m) model_busy_cnt++;
      if (!have) begin
        d = (wq.size() > 0) ? wq.pop_front() : $urandom;
        have = 1'b1;
      end
      busy_next = 1'b0;
      if ($urandom_range(99) < vpct) begin
        data_validIN = 1'b1; address_dataIN = d;
        if (!busy_m) begin
          if (sent < int'(b) + 1) begin
            for (int l = 0; l < 4; l++)
              if (be[l]) mem_m[idx+sent][8*l +: 8] = d[8*l +: 8];
            acc++;
            busy_next = ((acc % BEV) == 0);
          end
          sent++;
          have = 1'b0;
        end
      end
      busy_m = busy_next;
      tick();
    end
    exp_busy = busy_m;
    if (busy_m) model_busy_cnt++;
    end_transactionIN = 1'b1;
    tick();
    $display("WR  addr=%h be=%h burst=%0d beats=%0d", a, be, b, nbeats);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] b, input logic [31:0] busy_pat,
                         input bit rnd, input int abort_at);
    int idx, k, c;
    logic bz;
    tick();
    begin_transactionIN = 1'b1; address_dataIN = a; burst_sizeIN = b; read_n_writeIN = 1'b1;
    if (bad_m(a, b)) begin
      tick();
      exp_err = 1'b1; exp_end = 1'b1; busyIN = 1'($urandom);
      tick();
      $display("RD  addr=%h burst=%0d -> error", a, b);
      return;
    end
    idx = int'((a - BASE) >> 2);
    tick();
    if (abort_at == 0) begin
      end_transactionIN = 1'b1;
      tick();
      $display("RD  addr=%h burst=%0d aborted in fetch", a, b);
      return;
    end
    tick();
    k = 0; c = 1;
    while (k <= int'(b)) begin
      exp_dv = 1'b1; exp_data = mem_m[idx+k];
      if (rnd) bz = ($urandom_range(3) == 0);
      else bz = (c <= 32) ? busy_pat[c-1] : 1'b0;
      busyIN = bz;
      begin_transactionIN = ($urandom_range(7) == 0);
      read_n_writeIN = 1'($urandom);
      if (abort_at == c) begin
        end_transactionIN = 1'b1;
        tick();
        $display("RD  addr=%h burst=%0d aborted at data cycle %0d", a, b, c);
        return;
      end
      if (!bz) k++;
      c++;
      tick();
    end
    exp_end = 1'b1;
    tick();
    $display("RD  addr=%h burst=%0d cycles=%0d", a, b, c - 1);
  endtask

  // watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int kind, ix, nb, ab, r;
    logic [7:0]  b;
    logic [31:0] a;

    rst = 1'b1;
    address_dataIN = 32'h0; byte_enableIN = 4'h0; burst_sizeIN = 8'h0; read_n_writeIN = 1'b0;
    begin_transactionIN = 1'b0; end_transactionIN = 1'b0; data_validIN = 1'b0; busyIN = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // fill the whole memory (largest legal burst)
    do_write(BASE, 4'hF, 8'd255, 256, 100);

    // plain burst write then read back
    wq = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_write(BASE + 32'h10, 4'hF, 8'd3, 4, 100);
    check("pin_w4", mem_m[4], 32'h11111111);
    check("pin_w7", mem_m[7], 32'h44444444);
    dut_dv_cnt = 0;
    do_read(BASE + 32'h10, 8'd3, 32'h0, 1'b0, -1);
    check("burst_read_beats", dut_dv_cnt, 32'd4);

    // throttle: busy after beats 2 and 4
    dut_busy_cnt = 0; model_busy_cnt = 0;
    wq = {32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
    do_write(BASE + 32'h40, 4'hF, 8'd3, 4, 100);
    check("throttle_busy_dut", dut_busy_cnt, 32'd2);
    check("throttle_busy_model", model_busy_cnt, 32'd2);
    check("pin_w19", mem_m[19], 32'hA0000004);
    do_read(BASE + 32'h40, 8'd3, 32'h0, 1'b0, -1);

    // byte lanes
    wq = {32'hDEADBEEF};
    do_write(BASE + 32'h20, 4'hF, 8'd0, 1, 100);
    wq = {32'hAABBCCDD};
    do_write(BASE + 32'h20, 4'b0010, 8'd0, 1, 100);
    check("pin_lane", mem_m[8], 32'hDEADCCEF);
    do_read(BASE + 32'h20, 8'd0, 32'h0, 1'b0, -1);

    // read stall: beat 2 held for two extra cycles
    dut_dv_cnt = 0;
    do_read(BASE + 32'h10, 8'd2, 32'h6, 1'b0, -1);
    check("stall_dv_cycles", dut_dv_cnt, 32'd5);

    // errors
    dut_err_cnt = 0; dut_dv_cnt = 0;
    do_read(BASE + 32'h2, 8'd0, 32'h0, 1'b0, -1);
    check("err_misaligned_cnt", dut_err_cnt, 32'd1);
    check("err_misaligned_dv", dut_dv_cnt, 32'd0);
    dut_err_cnt = 0;
    do_write(BASE + 32'((SIZE - 2) * 4), 4'hF, 8'd3, 3, 100);
    check("err_range_cnt", dut_err_cnt, 32'd1);
    do_read(BASE + 32'((SIZE - 2) * 4), 8'd1, 32'h0, 1'b0, -1);
    do_read(BASE + 32'((SIZE - 1) * 4), 8'd0, 32'h0, 1'b0, -1);

    // reset during beat 2 of a 4-beat read
    wq = {32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004};
    do_write(BASE + 32'h100, 4'hF, 8'd3, 4, 100);
    check("pin_w64", mem_m[64], 32'hCAFE0001);
    tick();
    begin_transactionIN = 1'b1; address_dataIN = BASE + 32'h100;
    burst_sizeIN = 8'd3; read_n_writeIN = 1'b1;
    tick();
    tick(); exp_dv = 1'b1; exp_data = mem_m[64];
    tick(); exp_dv = 1'b1; exp_data = mem_m[65];
    #2;
    rst = 1'b1;
    exp_dv = 1'b0; exp_data = 32'h0;
    #1;
    check("rst_dv", data_validOUT, 32'd0);
    check("rst_data", address_dataOUT, 32'd0);
    check("rst_end", end_transactionOUT, 32'd0);
    tick(); tick();
    rst = 1'b0;
    $display("RST during read beat 2");
    do_read(BASE + 32'h100, 8'd3, 32'h0, 1'b0, -1);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(9);
      b = ($urandom_range(3) == 0) ? 8'($urandom_range(20)) : 8'($urandom_range(3));
      ix = $urandom_range(0, SIZE - 1 - int'(b));
      a = BASE + 32'(ix * 4);
      if (kind == 9) begin
        case ($urandom_range(3))
          0: a = a + 32'($urandom_range(1, 3));
          1: begin
               b = 8'($urandom_range(1, 10));
               a = BASE + 32'($urandom_range(SIZE - int'(b), SIZE - 1)) * 4;
             end
          2: a = BASE - 32'($urandom_range(1, 100)) * 4;
          default: a = BASE + 32'(SIZE + $urandom_range(0, 1000)) * 4;
        endcase
      end
      r = $urandom_range(9);
      if (r < 7) nb = int'(b) + 1;
      else if (r == 7) nb = $urandom_range(0, int'(b));
      else nb = int'(b) + 1 + $urandom_range(1, 3);
      ab = ($urandom_range(5) == 0) ? $urandom_range(0, int'(b) + 1) : -1;
      if ($urandom_range(1) == 1)
        do_write(a, 4'($urandom), b, nb, $urandom_range(50, 100));
      else
        do_read(a, b, 32'h0, 1'b1, ab);
    end

    // full sweep confirms every stored word
    do_read(BASE, 8'd255, 32'h0, 1'b0, -1);

    tick(); tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_memory_target.md
Name: bus_memory_target

Overview:
- Single-port, byte-enabled word memory acting as the responder (slave) on the system bus that the JTAG bus initiator drives.
- Accepts burst reads and writes framed by begin_transaction/end_transaction, throttles writes with busyOUT and honours initiator busyIN stalls on reads.
- Flags bad accesses with errorOUT.
- Serves as on-chip debug RAM and as the bench target for the initiator.

Parameters:
- BASE_ADDR, 32'h5555_0000, byte address of word 0 (word aligned).
- SIZE_WORDS, 256, memory depth in 32-bit words (power of two, 2..65536).
- BUSY_EVERY, 0, 0 = never throttle; N>0 = assert busyOUT for one cycle after every N accepted write beats.

Ports:
- system_clock  in  1  bus clock.
- system_reset  in  1  asynchronous, active-high reset.
- address_dataIN  in  32  address at begin cycle, write data on beats.
- byte_enableIN  in  4  byte lanes, sampled at begin.
- burst_sizeIN  in  8  beats minus one, sampled at begin.
- read_n_writeIN  in  1  1 = read, sampled at begin.
- begin_transactionIN  in  1  transaction start strobe.
- end_transactionIN  in  1  initiator ends write / aborts read.
- data_validIN  in  1  write beat valid.
- busyIN  in  1  initiator stall of read data.
- address_dataOUT  out  32  read data; 0 when data_validOUT=0.
- data_validOUT  out  1  read beat valid.
- end_transactionOUT  out  1  one-cycle end of read or error.
- busyOUT  out  1  write throttle.
- errorOUT  out  1  one-cycle bad-access strobe.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Memory contents are not cleared. Reset mid-transaction returns to IDLE immediately, with no end or error strobe.
- States: IDLE, WRITE, WR_DRAIN, RD_FETCH, RD_DATA, RD_END, ERROR.
- IDLE, on begin_transactionIN:
  - Latch address, byte_enable, burst, rnw.
  - Error check (any of):
    - address[1:0] != 0
    - word index (addr-BASE_ADDR)>>2 outside [0, SIZE_WORDS)
    - index+burst >= SIZE_WORDS
  - If error, go to ERROR; otherwise go to WRITE or RD_FETCH.
- begin_transactionIN outside IDLE is ignored.
- WRITE:
  - A beat is accepted when data_validIN=1 and busyOUT=0.
  - Each accepted beat writes the lanes enabled by the latched byte_enable to the current index, then index+1 and beat count+1.
  - Beats beyond burst+1 are ignored.
  - A beat presented while busyOUT=1 is not accepted; the initiator holds it.
  - busyOUT rule (BUSY_EVERY=N>0): high in the cycle after the N-th, 2N-th, … accepted beat.
  - end_transactionIN returns to IDLE in the same cycle; an early end keeps partial writes.
- RD_FETCH: one cycle (synchronous RAM read).
- RD_DATA:
  - Begin in cycle n gives the first data_validOUT in cycle n+2.
  - Beats are consecutive while busyIN=0.
  - If busyIN=1 in a cycle with data_validOUT=1, the same word is presented again the next cycle; the beat is not consumed.
  - Read data is always the full word; byte_enable is ignored.
  - After beat burst+1 is consumed, go to RD_END.
  - end_transactionIN during RD_FETCH or RD_DATA aborts to IDLE with no end_transactionOUT.
- RD_END: end_transactionOUT=1 for exactly one cycle, then IDLE.
- ERROR:
  - errorOUT=1 and end_transactionOUT=1 for one cycle.
  - Read: then IDLE.
  - Write: then WR_DRAIN, which discards beats (busyOUT=0) until end_transactionIN, then IDLE.
- Index arithmetic: log2(SIZE_WORDS) bits. Wrap cannot occur because of the range check.

Decomposition:
- Package bus_target_pkg: state enum, BEATS_W=8, WORD_W=32, address-to-index and range-check functions.
- One sub-module, bus_target_ram: SIZE_WORDS x 4 byte-lane RAM, synchronous read, per-lane write enable, one read or write port per cycle.

Test Plan:
- Write burst: burst_size=3, be=4'hF, addr BASE+0x10, data 11111111/22222222/33333333/44444444, then end. Read back with burst_size=3: data_validOUT in 4 consecutive cycles starting 2 cycles after begin, same data in order. end_transactionOUT exactly one cycle after the 4th beat.
- Byte lanes: word preloaded 0xDEADBEEF; write be=4'b0010, data 0xAABBCCDD. Single read returns 0xDEADCCEF.
- Read stall: 3-beat read with busyIN=1 during beat 2 for 2 cycles. Beat 2 word repeated 3 cycles, total data_validOUT high 5 cycles, order unchanged.
- Errors:
  - addr BASE+0x2 → errorOUT and end_transactionOUT for one cycle, no data_validOUT.
  - addr BASE+(SIZE_WORDS-2)*4 with burst_size=3 → error.
  - Following write beats ignored until end_transactionIN.
- Throttle: BUSY_EVERY=2, 4-beat write with data_validIN held. busyOUT high in cycle after beats 2 and 4. All 4 words stored exactly once.
- Reset: assert system_reset during beat 2 of a 4-beat read. Outputs 0 immediately. A new read after release returns the stored data; memory is intact.
